// File: rtl/pio_avalon_master.sv
// Avalon-MM initiator for PIO-style slaves. It accepts one command on a valid/ready
// stream, runs a single chipselect/write_n transfer, and returns a registered response.
module pio_avalon_master #(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    // The wait counter only has to reach TIMEOUT_CYCLES-1; the stalled cycle after that aborts.
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAT_LAST = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_LATENCY,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                chipselect_q, chipselect_d;
    logic                write_n_q, write_n_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;
    logic                is_write_q, is_write_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_error_q, rsp_error_d;

    // NOTE: every *_d starts as its *_q so no path through the case leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        chipselect_d = chipselect_q;
        write_n_d    = write_n_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        is_write_d   = is_write_q;
        wait_cnt_d   = wait_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_error_d  = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d      = S_ACCESS;
                    chipselect_d = 1'b1;
                    write_n_d    = ~cmd_write;
                    address_d    = cmd_addr;
                    writedata_d  = cmd_wdata;
                    is_write_d   = cmd_write;
                    wait_cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (!avm_waitrequest) begin
                    chipselect_d = 1'b0;
                    write_n_d    = 1'b1;
                    if (is_write_q) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_error_d = 1'b0;
                    end else if (READ_LATENCY == 0) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = avm_readdata;
                        rsp_error_d = 1'b0;
                    end else begin
                        state_d   = S_LATENCY;
                        lat_cnt_d = '0;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    chipselect_d = 1'b0;
                    write_n_d    = 1'b1;
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_error_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_LATENCY: begin
                // Read data is valid exactly READ_LATENCY cycles after the completing cycle.
                if (lat_cnt_q == LAT_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = avm_readdata;
                    rsp_error_d = 1'b0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            address_q    <= '0;
            writedata_q  <= '0;
            is_write_q   <= 1'b0;
            wait_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            chipselect_q <= chipselect_d;
            write_n_q    <= write_n_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            is_write_q   <= is_write_d;
            wait_cnt_q   <= wait_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_error      = rsp_error_q;
    assign avm_chipselect = chipselect_q;
    assign avm_write_n    = write_n_q;
    assign avm_address    = address_q;
    assign avm_writedata  = writedata_q;

endmodule

// File: tb/tb_pio_avalon_master.sv
// Randomized scoreboard bench for pio_avalon_master: a PIO register-file slave with
// per-transfer stalls, a transfer-level reference model, and a response monitor.
module tb_pio_avalon_master;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 0;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_error;
    logic [DATA_W-1:0] rsp_rdata;
    logic              avm_chipselect, avm_write_n, avm_waitrequest;
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata, avm_readdata;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          cs;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_regs [4];
    logic [31:0] pio_regs [4];
    int vectors = 0, miscompares = 0;
    int cyc = 0, cs_cnt = 0, stall_left = 0, hold_cycles = 0;
    int exp_writes = 0, bus_writes = 0;
    bit lat_seen = 0;

    pio_avalon_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RD_LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // PIO slave: register file written on a completed write strobe.
    always @(posedge clk) begin
        if (reset_n && avm_chipselect && !avm_waitrequest && !avm_write_n) begin
            pio_regs[avm_address] <= avm_writedata;
            bus_writes <= bus_writes + 1;
        end
    end

    // Slave stall and read data; read data is junk except in the completing cycle.
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        forever begin
            @(negedge clk);
            if (avm_chipselect && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                avm_readdata = $urandom;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = (avm_chipselect && avm_write_n) ? pio_regs[avm_address] : $urandom;
            end
        end
    end

    // Monitor: drives rsp_ready, checks bus activity and responses against the scoreboard.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_cycles > 0) begin
                rsp_ready = 1'b0;
                hold_cycles--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (avm_chipselect) begin
                if (sb.size() == 0) check("cs_unexpected", avm_chipselect, 0);
                else begin
                    cs_cnt++;
                    check("bus_hold", {avm_write_n, avm_address, avm_writedata},
                          {~sb[0].wr, sb[0].addr, sb[0].wdata});
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
                else begin
                    if (!lat_seen) begin
                        check("latency", cyc - sb[0].acc, sb[0].lat);
                        check("cs_cycles", cs_cnt, sb[0].cs);
                        lat_seen = 1;
                    end
                    check("rsp_rdata", rsp_rdata, sb[0].rdata);
                    check("rsp_error", rsp_error, sb[0].err);
                    check("cmd_ready_busy", cmd_ready, 0);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        lat_seen = 0;
                        cs_cnt = 0;
                    end
                end
            end
        end
    end

    // Issue one command; while the block is busy, drive junk (possibly valid) commands.
    task automatic send(input bit wr, input logic [1:0] addr, input logic [31:0] wdata,
                        input int stall);
        exp_t e;
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                cmd_valid = 1'b1;
                cmd_write = wr;
                cmd_addr  = addr;
                cmd_wdata = wdata;
                e.wr = wr; e.addr = addr; e.wdata = wdata; e.acc = cyc;
                if (stall >= TO) begin
                    e.err = 1; e.rdata = '0; e.cs = TO; e.lat = TO + 1;
                end else begin
                    e.err = 0; e.cs = stall + 1; e.lat = stall + 2 + (wr ? 0 : RD_LAT);
                    if (wr) begin
                        ref_regs[addr] = wdata;
                        exp_writes++;
                        e.rdata = '0;
                    end else begin
                        e.rdata = ref_regs[addr];
                    end
                end
                sb.push_back(e);
                @(posedge clk);
                stall_left = stall;
                #1;
                cmd_valid = 1'b0;
                cmd_write = $urandom_range(0, 1);
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                done = 1;
            end else begin
                cmd_valid = $urandom_range(0, 1);
                cmd_write = $urandom_range(0, 1);
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
            end
        end
        if (!done) bound_fail("cmd_accept");
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) bound_fail("drain");
    endtask

    function automatic int rand_stall();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 0;
        if (r < 85) return $urandom_range(1, 3);
        return $urandom_range(TO, TO + 2);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            ref_regs[i] = '0;
            pio_regs[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_chipselect", avm_chipselect, 0);
        check("rst_write_n", avm_write_n, 1);
        check("rst_address", avm_address, 0);
        check("rst_writedata", avm_writedata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Directed: write, read back, stalled write, timeout, held response.
        send(1'b1, 2'd0, 32'h0000_0001, 0);
        send(1'b0, 2'd0, 32'h0, 0);
        send(1'b0, 2'd1, 32'h0, 0);
        drain();
        check("pio_out_port", pio_regs[0], 32'h1);
        send(1'b1, 2'd2, 32'hA5A5_0002, 3);
        send(1'b1, 2'd1, 32'hDEAD_BEEF, TO);
        send(1'b0, 2'd2, 32'h0, 0);
        send(1'b0, 2'd1, 32'h0, 1);
        drain();
        hold_cycles = 8;
        send(1'b0, 2'd2, 32'h0, 0);
        drain();

        for (int n = 0; n < 200; n++)
            send($urandom_range(0, 1), $urandom_range(0, 3), $urandom, rand_stall());
        drain();
        check("bus_write_count", bus_writes, exp_writes);
        for (int i = 0; i < 4; i++) check("pio_reg_final", pio_regs[i], ref_regs[i]);

        // Reset in the middle of a stalled access drops the transfer without a response.
        send(1'b1, 2'd3, 32'h1234_5678, 20);
        #2;
        check("cs_before_reset", avm_chipselect, 1);
        reset_n = 1'b0;
        sb.delete();
        cs_cnt = 0;
        lat_seen = 0;
        stall_left = 0;
        #1;
        check("reset_mid_chipselect", avm_chipselect, 0);
        check("reset_mid_write_n", avm_write_n, 1);
        check("reset_mid_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_mid_reset", cmd_ready, 1);
        check("no_write_on_abort", pio_regs[3], ref_regs[3]);
        send(1'b0, 2'd0, 32'h0, 0);
        send(1'b1, 2'd3, 32'hCAFE_F00D, 2);
        send(1'b0, 2'd3, 32'h0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
